// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use interlock, memory-wait freeze,
// wrong-path squash after taken branches and exceptions, PC redirect and delay-slot tracking.
module pipeline_ctrl #(
  parameter int unsigned REGADDR_WIDTH = 5,
  parameter int unsigned FLUSH_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REGADDR_WIDTH-1:0] dec_rs,
  input  logic [REGADDR_WIDTH-1:0] dec_rt,
  input  logic                     dec_uses_rs,
  input  logic                     dec_uses_rt,
  input  logic                     dec_is_branch,
  input  logic                     ex_is_load,
  input  logic [REGADDR_WIDTH-1:0] ex_wb_addr,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_dest,
  input  logic                     mem_busy,
  input  logic                     exc_valid,
  input  logic [31:0]              exc_target,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     stall_ex,
  output logic                     stall_mem,
  output logic                     clear_id,
  output logic                     clear_ex,
  output logic                     clear_mem,
  output logic                     in_delay_slot,
  output logic                     pc_redirect_valid,
  output logic [31:0]              pc_redirect_addr
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        squash_pend_q, squash_pend_d;
  logic        in_delay_slot_q, in_delay_slot_d;
  logic        load_use;

  assign load_use = ex_is_load && (ex_wb_addr != '0) &&
                    ((dec_uses_rs && (dec_rs == ex_wb_addr)) ||
                     (dec_uses_rt && (dec_rt == ex_wb_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StRun;
      flush_cnt_q     <= 4'd0;
      squash_pend_q   <= 1'b0;
      in_delay_slot_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      squash_pend_q   <= squash_pend_d;
      in_delay_slot_q <= in_delay_slot_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    squash_pend_d   = squash_pend_q;
    in_delay_slot_d = in_delay_slot_q;
    if (exc_valid) begin
      state_d         = StFlush;
      flush_cnt_d     = 4'(FLUSH_CYCLES);
      squash_pend_d   = 1'b0;
      in_delay_slot_d = 1'b0;
    end else if (!mem_busy) begin
      // Squash flag is consumed on any unstalled cycle; a fresh taken branch re-arms it.
      if (squash_pend_q) squash_pend_d = 1'b0;
      if (state_q == StFlush) begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        if (flush_cnt_q <= 4'd1) begin
          state_d     = StRun;
          flush_cnt_d = 4'd0;
        end
      end else if (branch_taken) begin
        squash_pend_d = 1'b1;
      end
      if (!stall_if) in_delay_slot_d = dec_is_branch && !clear_id;
    end
  end

  always_comb begin
    stall_if          = 1'b0;
    stall_id          = 1'b0;
    stall_ex          = 1'b0;
    stall_mem         = 1'b0;
    clear_id          = 1'b0;
    clear_ex          = 1'b0;
    clear_mem         = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect_addr  = 32'd0;
    if (exc_valid) begin
      pc_redirect_valid = 1'b1;
      pc_redirect_addr  = exc_target;
      clear_id          = 1'b1;
      clear_ex          = 1'b1;
      clear_mem         = 1'b1;
    end else if (mem_busy) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else begin
      if (state_q == StFlush) begin
        clear_id = 1'b1;
      end else begin
        if (branch_taken) begin
          pc_redirect_valid = 1'b1;
          pc_redirect_addr  = branch_dest;
        end
        if (load_use) begin
          stall_if = 1'b1;
          clear_id = 1'b1;
        end
      end
      if (squash_pend_q) clear_id = 1'b1;
    end
  end

  assign in_delay_slot = in_delay_slot_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, branch squash, memory freeze, exception flush, reset.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dec_rs, dec_rt, ex_wb_addr;
  logic        dec_uses_rs, dec_uses_rt, dec_is_branch, ex_is_load;
  logic        branch_taken, mem_busy, exc_valid;
  logic [31:0] branch_dest, exc_target;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        clear_id, clear_ex, clear_mem, in_delay_slot, pc_redirect_valid;
  logic [31:0] pc_redirect_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REGADDR_WIDTH(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_is_branch(dec_is_branch), .ex_is_load(ex_is_load), .ex_wb_addr(ex_wb_addr),
    .branch_taken(branch_taken), .branch_dest(branch_dest), .mem_busy(mem_busy),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .clear_id(clear_id), .clear_ex(clear_ex), .clear_mem(clear_mem),
    .in_delay_slot(in_delay_slot), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect_addr(pc_redirect_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Packs {stall_if,stall_id,stall_ex,stall_mem,clear_id,clear_ex,clear_mem,redirect}.
  function automatic logic [31:0] outs();
    return {24'd0, stall_if, stall_id, stall_ex, stall_mem, clear_id, clear_ex, clear_mem,
            pc_redirect_valid};
  endfunction

  task automatic idle_inputs();
    dec_rs = 0; dec_rt = 0; dec_uses_rs = 0; dec_uses_rt = 0; dec_is_branch = 0;
    ex_is_load = 0; ex_wb_addr = 0; branch_taken = 0; branch_dest = 0;
    mem_busy = 0; exc_valid = 0; exc_target = 0;
  endtask

  // Advance one clock, then leave 1 time unit for new inputs to be applied before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    #1 check("reset_outs", outs(), 32'h00);
    tick();
    rst = 1'b0;
    #1 check("post_reset_outs", outs(), 32'h00);
    check("post_reset_ids", in_delay_slot, 0);

    // Load-use on rs: lw $5 in EX, addu $6,$5,$7 in ID.
    ex_is_load = 1; ex_wb_addr = 5; dec_rs = 5; dec_rt = 7; dec_uses_rs = 1; dec_uses_rt = 1;
    #1 check("load_use_rs", outs(), 32'h88);
    tick();
    ex_is_load = 0;
    #1 check("load_use_released", outs(), 32'h00);
    ex_is_load = 1; dec_rs = 1; dec_rt = 5;
    #1 check("load_use_rt", outs(), 32'h88);
    dec_uses_rt = 0;
    #1 check("rt_unused_no_stall", outs(), 32'h00);
    ex_wb_addr = 0; dec_rs = 0; dec_rt = 0; dec_uses_rs = 1; dec_uses_rt = 1;
    #1 check("r0_no_stall", outs(), 32'h00);
    idle_inputs();

    // Taken branch: branch in ID, then resolved in EX with delay slot in ID.
    dec_is_branch = 1;
    tick();
    dec_is_branch = 0; branch_taken = 1; branch_dest = 32'h8000_1000;
    #1 check("br_outs", outs(), 32'h01);
    check("br_addr", pc_redirect_addr, 32'h8000_1000);
    check("br_in_delay_slot", in_delay_slot, 1);
    tick();
    branch_taken = 0;
    #1 check("br_squash", outs(), 32'h08);
    check("br_ids_after", in_delay_slot, 0);
    tick();
    #1 check("br_settled", outs(), 32'h00);

    // Taken branch held by mem_busy for 3 cycles.
    branch_taken = 1; branch_dest = 32'h8000_2000; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("busy_stall_%0d", i), outs(), 32'hF0);
      tick();
    end
    mem_busy = 0;
    #1 check("busy_release_redirect", outs(), 32'h01);
    check("busy_release_addr", pc_redirect_addr, 32'h8000_2000);
    tick();
    branch_taken = 0; mem_busy = 1;
    #1 check("squash_held_busy", outs(), 32'hF0);
    tick();
    mem_busy = 0;
    #1 check("squash_after_busy", outs(), 32'h08);
    tick();
    #1 check("squash_done", outs(), 32'h00);

    // Exception with FLUSH_CYCLES=2; a branch during FLUSH is ignored.
    exc_valid = 1; exc_target = 32'h8000_0180; mem_busy = 1;
    #1 check("exc_outs", outs(), 32'h0F);
    check("exc_addr", pc_redirect_addr, 32'h8000_0180);
    tick();
    exc_valid = 0; mem_busy = 0; branch_taken = 1; branch_dest = 32'h1234_5678;
    #1 check("flush_t1", outs(), 32'h08);
    tick();
    branch_taken = 0;
    #1 check("flush_t2", outs(), 32'h08);
    tick();
    #1 check("flush_t3_run", outs(), 32'h00);

    // Exception and branch together: exception target only, no squash afterwards.
    exc_valid = 1; branch_taken = 1; branch_dest = 32'hDEAD_BEE0;
    #1 check("exc_br_addr", pc_redirect_addr, 32'h8000_0180);
    tick();
    exc_valid = 0; branch_taken = 0;
    tick();
    tick();
    #1 check("exc_br_no_squash", outs(), 32'h00);

    // Reset mid-FLUSH aborts it.
    exc_valid = 1;
    tick();
    exc_valid = 0; rst = 1; dec_is_branch = 1;
    tick();
    rst = 0; dec_is_branch = 0;
    #1 check("rst_flush_outs", outs(), 32'h00);
    check("rst_flush_ids", in_delay_slot, 0);

    // Reset with a pending squash aborts it.
    branch_taken = 1;
    tick();
    branch_taken = 0; rst = 1;
    tick();
    rst = 0;
    #1 check("rst_squash_outs", outs(), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
